rvfi_mem_bus_model: RTL
=======================

# rvfi_mem_bus_model

Parametrised, protocol-legal memory-bus environment model for riscv-formal core wrappers. It replaces free-running random `gnt`/`rvalid`/`rdata`/`err` registers on one core bus port (instruction or data), using per-cycle nondeterministic choice inputs. It filters those choices into a legal req/gnt/rvalid transaction stream with bounded outstanding count, bounded grant and response latency, in-order responses and optional bus-error injection. It also flags core-side protocol violations. One instance sits per bus port between the `rvformal_rand_reg` sources and the core under test.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` byte enables
- `MAX_OUTSTANDING`, 2, granted-but-unanswered transactions allowed (≥1)
- `MAX_GNT_DELAY`, 4, max consecutive stalled cycles of a pending request while space exists (≥0)
- `MAX_RVALID_DELAY`, 4, max cycles a head transaction waits beyond its earliest response cycle (≥0)
- `ERR_EN`, 1, 1 allows `err_o`; 0 forces it low

- `clk_i` in 1: single clock
- `rst_ni` in 1: reset, synchronous, active-low
- `req_i` in 1: core request
- `addr_i` in ADDR_W: request address
- `we_i` in 1: write enable
- `be_i` in DATA_W/8: byte enables
- `wdata_i` in DATA_W: write data
- `gnt_o` out 1: grant, combinational
- `rvalid_o` out 1: response valid
- `rdata_o` out DATA_W: read data
- `err_o` out 1: bus error with response
- `rand_gnt_i` in 1: nondeterministic grant choice
- `rand_rvalid_i` in 1: nondeterministic response choice
- `rand_rdata_i` in DATA_W: nondeterministic read data
- `rand_err_i` in 1: nondeterministic error choice
- `outstanding_o` out $clog2(MAX_OUTSTANDING+1): current outstanding count
- `proto_err_o` out 1: sticky core protocol violation flag

## Operation
- State: `count_q` (outstanding), `gwait_q` (grant-stall counter), `rwait_q` (head-response wait counter), `pend_q` plus captured `addr/we/be/wdata` of an ungranted request, `we_fifo` (depth MAX_OUTSTANDING, in-order `we` per outstanding transaction), `proto_err_q`.
- Response: `rvalid_o = (count_q != 0) && (rand_rvalid_i || rwait_q == MAX_RVALID_DELAY)`. `rdata_o = rand_rdata_i` when `rvalid_o` and head `we == 0`, else 0. `err_o = ERR_EN && rand_err_i && rvalid_o`. A pop occurs on every `rvalid_o`.
- Space: `space = (count_q < MAX_OUTSTANDING) || rvalid_o`, so a response frees its slot in the same cycle.
- Grant: `gnt_o = req_i && space && (rand_gnt_i || gwait_q == MAX_GNT_DELAY)`. A push of `we_i` occurs on `gnt_o`.
- Count: `count_d = count_q + gnt_o - rvalid_o`. A simultaneous grant and response leaves the count unchanged. The FIFO never over- or under-flows.
- `gwait_q`:
  - increments when `req_i && space && !gnt_o`
  - clears on `gnt_o` or `!req_i`
  - holds when `!space`
  - saturates at MAX_GNT_DELAY
- `rwait_q`:
  - clears on `rvalid_o` or when `count_q == 0`
  - otherwise increments, saturating at MAX_RVALID_DELAY
- Response is never given in the grant cycle (depends on `count_q` only).
- Protocol check: if `pend_q` (req high, not granted last cycle), `req_i` must be high with identical `addr_i/we_i/be_i/wdata_i`. Otherwise `proto_err_q` is set and held until reset. `pend_q <= req_i && !gnt_o`, and the request fields are captured whenever `pend_q` is 0.

## Timing
- Reset (`rst_ni == 0` at a clock edge): all state clears.
  - `gnt_o`, `rvalid_o`, `err_o`, `proto_err_o` = 0; `rdata_o` = 0; `outstanding_o` = 0.
  - Reset mid-transaction discards outstanding transactions; no response follows reset.
- `gnt_o` is combinational from `req_i` and registered state. All other outputs derive from registered state plus `rand_*` inputs, giving no combinational path from `req_i` to `rvalid_o`.
- Grant is guaranteed within MAX_GNT_DELAY+1 cycles of `req_i` rising while space persists.
- A head transaction is answered no earlier than the cycle after its grant, and no later than MAX_RVALID_DELAY cycles after becoming head plus one.
- With MAX_RVALID_DELAY = 0, `rvalid_o` is asserted every cycle `count_q != 0`.
- With MAX_GNT_DELAY = 0, every request with space is granted immediately.

## Test plan
- MAX_OUTSTANDING=2, all `rand_*`=0, `req_i` held with addr 0x100:
  - `gnt_o` in cycle 5 (MAX_GNT_DELAY=4)
  - `rvalid_o` 5 cycles later
  - `rdata_o`=0, `outstanding_o` 1→0.
- `rand_gnt_i`=1, `rand_rvalid_i`=0, `req_i` held:
  - grants in two consecutive cycles, then `gnt_o`=0 with `outstanding_o`=2.
  - Forcing `rand_rvalid_i`=1 gives grant and response in the same cycle; `outstanding_o` stays 2.
- Read then write granted back-to-back, `rand_rvalid_i`=1, `rand_rdata_i`=0xDEADBEEF:
  - first response `rdata_o`=0xDEADBEEF
  - second response `rdata_o`=0.
- `rand_err_i`=1 with ERR_EN=1 gives `err_o` only in `rvalid_o` cycles; with ERR_EN=0, `err_o` stays 0.
- Ungranted request whose addr changes 0x100→0x104: `proto_err_o`=1 next cycle, sticky until `rst_ni`=0.
- Assert `rst_ni`=0 with `outstanding_o`=2: next cycle all outputs 0, and no `rvalid_o` afterwards until a new grant.

Source files
------------

// File: rtl/rvfi_mem_bus_model.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rvfi_mem_bus_model: legal req/gnt/rvalid bus environment for riscv-formal  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rvfi_mem_bus_model #(
   parameter int ADDR_W           = 32,
   parameter int DATA_W           = 32,
   parameter int MAX_OUTSTANDING  = 2,
   parameter int MAX_GNT_DELAY    = 4,
   parameter int MAX_RVALID_DELAY = 4,
   parameter bit ERR_EN           = 1'b1
) (
   input  logic                                       clk_i,
   input  logic                                       rst_ni,
   input  logic                                       req_i,
   input  logic [ADDR_W-1:0]                          addr_i,
   input  logic                                       we_i,
   input  logic [DATA_W/8-1:0]                        be_i,
   input  logic [DATA_W-1:0]                          wdata_i,
   output logic                                       gnt_o,
   output logic                                       rvalid_o,
   output logic [DATA_W-1:0]                          rdata_o,
   output logic                                       err_o,
   input  logic                                       rand_gnt_i,
   input  logic                                       rand_rvalid_i,
   input  logic [DATA_W-1:0]                          rand_rdata_i,
   input  logic                                       rand_err_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding_o,
   output logic                                       proto_err_o
);

   localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int c_GW_W  = (MAX_GNT_DELAY > 0) ? $clog2(MAX_GNT_DELAY + 1) : 1;
   localparam int c_RW_W  = (MAX_RVALID_DELAY > 0) ? $clog2(MAX_RVALID_DELAY + 1) : 1;
   localparam int c_BE_W  = DATA_W / 8;

   localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_OUTSTANDING);
   localparam logic [c_GW_W-1:0]  c_GW_MAX  = c_GW_W'(MAX_GNT_DELAY);
   localparam logic [c_RW_W-1:0]  c_RW_MAX  = c_RW_W'(MAX_RVALID_DELAY);

   logic [c_CNT_W-1:0]         r_count;
   logic [c_GW_W-1:0]          r_gwait;
   logic [c_RW_W-1:0]          r_rwait;
   logic                       r_pend;
   logic [ADDR_W-1:0]          r_addr;
   logic                       r_we;
   logic [c_BE_W-1:0]          r_be;
   logic [DATA_W-1:0]          r_wdata;
   logic [MAX_OUTSTANDING-1:0] r_we_fifo;
   logic                       r_proto_err;

   logic                       w_rvalid;
   logic                       w_space;
   logic                       w_gnt;
   logic [c_CNT_W-1:0]         w_wr_idx;
   logic [c_CNT_W-1:0]         w_count_d;
   logic [c_GW_W-1:0]          w_gwait_d;
   logic [c_RW_W-1:0]          w_rwait_d;
   logic [MAX_OUTSTANDING-1:0] w_we_fifo_d;
   logic                       w_req_changed;

   // Response depends only on registered count, so never in the grant cycle.
   assign w_rvalid = (r_count != '0) && (rand_rvalid_i || (r_rwait == c_RW_MAX));
   assign w_space  = (r_count < c_MAX_CNT) || w_rvalid;
   assign w_gnt    = req_i && w_space && (rand_gnt_i || (r_gwait == c_GW_MAX));

   assign gnt_o         = w_gnt;
   assign rvalid_o      = w_rvalid;
   assign rdata_o       = (w_rvalid && !r_we_fifo[0]) ? rand_rdata_i : '0;
   assign err_o         = ERR_EN && rand_err_i && w_rvalid;
   assign outstanding_o = r_count;
   assign proto_err_o   = r_proto_err;

   assign w_count_d = r_count + c_CNT_W'(w_gnt) - c_CNT_W'(w_rvalid);
   assign w_wr_idx  = r_count - c_CNT_W'(w_rvalid);

   // Head lives at bit 0; a pop shifts the queue down before the new entry lands.
   always_comb begin
      w_we_fifo_d = r_we_fifo;
      if (w_rvalid) begin
         w_we_fifo_d = r_we_fifo >> 1;
      end
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         if (w_gnt && (w_wr_idx == c_CNT_W'(i))) begin
            w_we_fifo_d[i] = we_i;
         end
      end
   end

   always_comb begin
      w_gwait_d = r_gwait;
      if (!req_i || w_gnt) begin
         w_gwait_d = '0;
      end else if (w_space && (r_gwait != c_GW_MAX)) begin
         w_gwait_d = r_gwait + 1'b1;
      end
   end

   always_comb begin
      w_rwait_d = r_rwait;
      if (w_rvalid || (r_count == '0)) begin
         w_rwait_d = '0;
      end else if (r_rwait != c_RW_MAX) begin
         w_rwait_d = r_rwait + 1'b1;
      end
   end

   assign w_req_changed = !req_i || (addr_i != r_addr) || (we_i != r_we) ||
                          (be_i != r_be) || (wdata_i != r_wdata);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_count     <= '0;
         r_gwait     <= '0;
         r_rwait     <= '0;
         r_pend      <= 1'b0;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_be        <= '0;
         r_wdata     <= '0;
         r_we_fifo   <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_count   <= w_count_d;
         r_gwait   <= w_gwait_d;
         r_rwait   <= w_rwait_d;
         r_we_fifo <= w_we_fifo_d;
         r_pend    <= req_i && !w_gnt;
         if (!r_pend) begin
            r_addr  <= addr_i;
            r_we    <= we_i;
            r_be    <= be_i;
            r_wdata <= wdata_i;
         end
         if (r_pend && w_req_changed) begin
            r_proto_err <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
